// File: rtl/bp_resolve_queue_if.sv
// Fetch/execute-side signals of the branch resolve queue, grouped for port wiring.
// master = pipeline driving predictions/resolutions, slave = the queue itself.
interface bp_resolve_queue_if #(
    parameter int PTR_W = 2,
    parameter int CNT_W = 16
);
    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             flush;
    logic             upd_en;
    logic             upd_result;
    logic             mispredict;
    logic [PTR_W:0]   occupancy;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             err_overflow;
    logic             err_underflow;

    modport master (
        output pred_valid, pred_taken, res_valid, res_taken, flush,
        input  pred_ready, upd_en, upd_result, mispredict, occupancy,
               br_cnt, miss_cnt, err_overflow, err_underflow
    );

    modport slave (
        input  pred_valid, pred_taken, res_valid, res_taken, flush,
        output pred_ready, upd_en, upd_result, mispredict, occupancy,
               br_cnt, miss_cnt, err_overflow, err_underflow
    );
endinterface

// File: rtl/bp_resolve_queue.sv
// In-order queue of fetch-time predictions; resolves against execute outcomes and strobes predictor updates.
// Latency: 1 clk res_valid -> upd_en; backpressure: pred_ready = count < DEPTH, no push bypass when full.
module bp_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    bp_resolve_queue_if.slave   q
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic             mem_q [DEPTH];
    logic             mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             upd_en_q, upd_en_d;
    logic             upd_result_q, upd_result_d;
    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             err_overflow_q, err_overflow_d;
    logic             err_underflow_q, err_underflow_d;

    logic pred_ready;
    logic resolve;
    logic head;
    logic miss;
    logic kill;
    logic push;

    assign pred_ready = (count_q != FULL_CNT);

    always_comb begin
        resolve = q.res_valid && (count_q != '0);
        head    = mem_q[rd_ptr_q];
        miss    = resolve && (head != q.res_taken);
        // A mispredict or flush makes every younger entry (and this cycle's push) wrong-path.
        kill    = q.flush || miss;
        push    = q.pred_valid && pred_ready && !kill;

        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        upd_en_d        = resolve;
        upd_result_d    = resolve ? q.res_taken : 1'b0;
        mispredict_d    = miss;
        br_cnt_d        = br_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        err_overflow_d  = err_overflow_q;
        err_underflow_d = err_underflow_q;

        if (push) begin
            mem_d[wr_ptr_q] = q.pred_taken;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (kill) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(resolve);
            rd_ptr_d = rd_ptr_q + PTR_W'(resolve);
        end

        if (resolve && (br_cnt_q != '1))
            br_cnt_d = br_cnt_q + CNT_W'(1);
        if (miss && (miss_cnt_q != '1))
            miss_cnt_d = miss_cnt_q + CNT_W'(1);

        if (q.pred_valid && !pred_ready)
            err_overflow_d = 1'b1;
        if (q.res_valid && (count_q == '0))
            err_underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 1'b0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            upd_en_q        <= 1'b0;
            upd_result_q    <= 1'b0;
            mispredict_q    <= 1'b0;
            br_cnt_q        <= '0;
            miss_cnt_q      <= '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            mem_q           <= mem_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            upd_en_q        <= upd_en_d;
            upd_result_q    <= upd_result_d;
            mispredict_q    <= mispredict_d;
            br_cnt_q        <= br_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign q.pred_ready    = pred_ready;
    assign q.upd_en        = upd_en_q;
    assign q.upd_result    = upd_result_q;
    assign q.mispredict    = mispredict_q;
    assign q.occupancy     = count_q;
    assign q.br_cnt        = br_cnt_q;
    assign q.miss_cnt      = miss_cnt_q;
    assign q.err_overflow  = err_overflow_q;
    assign q.err_underflow = err_underflow_q;
endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench: expected update strobes go into a scoreboard queue, a negedge monitor pops and compares them.
module tb_bp_resolve_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // Each entry is {upd_result, mispredict} expected one cycle after a resolve.
    logic [1:0] exp_q [$];

    bp_resolve_queue_if #(.PTR_W(PTR_W), .CNT_W(CNT_W)) bus ();

    bp_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected update; stray pulses are errors.
    always @(negedge clk) begin
        if (bus.upd_en === 1'b1) begin
            logic [1:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL upd_en_unexpected: got 1 expected 0");
            end else begin
                e = exp_q.pop_front();
                chk("upd_result", int'(bus.upd_result), int'(e[1]));
                chk("mispredict", int'(bus.mispredict), int'(e[0]));
            end
        end else if (bus.mispredict !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL mispredict_without_upd: got %b expected 0", bus.mispredict);
        end
    end

    // One clock of stimulus, entered and left at a negedge; inputs drop right after the edge.
    task automatic cyc(input logic pv, input logic pt, input logic rv, input logic rt,
                       input logic fl, input bit exp_upd, input bit exp_mis);
        bus.pred_valid = pv;
        bus.pred_taken = pt;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        bus.flush      = fl;
        if (exp_upd) exp_q.push_back({rt, exp_mis});
        @(posedge clk);
        #1;
        bus.pred_valid = 1'b0;
        bus.pred_taken = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        bus.flush      = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic pt);
        cyc(1'b1, pt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve_ok(input logic rt);
        cyc(1'b0, 1'b0, 1'b1, rt, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] wrap_p;
        logic [7:0] wrap_r;
        bus.pred_valid = 1'b0;
        bus.pred_taken = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        bus.flush      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_occupancy", int'(bus.occupancy), 0);
        chk("reset_pred_ready", int'(bus.pred_ready), 1);
        chk("reset_upd_en", int'(bus.upd_en), 0);
        chk("reset_br_cnt", int'(bus.br_cnt), 0);
        chk("reset_miss_cnt", int'(bus.miss_cnt), 0);
        chk("reset_err_overflow", int'(bus.err_overflow), 0);
        chk("reset_err_underflow", int'(bus.err_underflow), 0);

        // Three predictions, then two matching resolves back to back.
        push(1'b1); push(1'b0); push(1'b1);
        chk("push3_occupancy", int'(bus.occupancy), 3);
        chk("push3_pred_ready", int'(bus.pred_ready), 1);
        resolve_ok(1'b1);
        resolve_ok(1'b0);
        chk("res2_br_cnt", int'(bus.br_cnt), 2);
        chk("res2_occupancy", int'(bus.occupancy), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_upd_en", int'(bus.upd_en), 0);

        // Full of taken predictions, actual not-taken: recovery empties the queue.
        push(1'b1); push(1'b1); push(1'b1);
        chk("full_occupancy", int'(bus.occupancy), 4);
        chk("full_pred_ready", int'(bus.pred_ready), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("miss_occupancy", int'(bus.occupancy), 0);
        chk("miss_miss_cnt", int'(bus.miss_cnt), 1);
        chk("miss_br_cnt", int'(bus.br_cnt), 3);

        // Mispredict with a same-cycle push: the push is wrong-path and discarded.
        push(1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("kill_push_occupancy", int'(bus.occupancy), 0);
        chk("kill_miss_cnt", int'(bus.miss_cnt), 2);
        chk("kill_err_overflow", int'(bus.err_overflow), 0);

        // Overflow: a fifth push is dropped and sets the sticky flag.
        push(1'b1); push(1'b0); push(1'b1); push(1'b0);
        chk("ovf_pred_ready", int'(bus.pred_ready), 0);
        push(1'b1);
        chk("ovf_occupancy", int'(bus.occupancy), 4);
        chk("ovf_err_overflow", int'(bus.err_overflow), 1);

        // Queue [1,0,1,0]; pop one, then 8 push+resolve pairs to wrap the pointers.
        resolve_ok(1'b1);
        wrap_p = 8'b1101_0011;   // pushes, LSB first: 1,1,0,0,1,0,1,1
        wrap_r = 8'b1001_1010;   // heads, LSB first:  0,1,0,1,1,0,0,1
        for (int i = 0; i < 8; i++)
            cyc(1'b1, wrap_p[i], 1'b1, wrap_r[i], 1'b0, 1'b1, 1'b0);
        chk("wrap_occupancy", int'(bus.occupancy), 3);
        chk("wrap_br_cnt", int'(bus.br_cnt), 13);
        chk("wrap_miss_cnt", int'(bus.miss_cnt), 2);
        chk("wrap_err_overflow_held", int'(bus.err_overflow), 1);

        // Drain [0,1,1], then resolve while empty together with a push.
        resolve_ok(1'b0); resolve_ok(1'b1); resolve_ok(1'b1);
        chk("drain_occupancy", int'(bus.occupancy), 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("unf_err_underflow", int'(bus.err_underflow), 1);
        chk("unf_occupancy", int'(bus.occupancy), 1);
        chk("unf_br_cnt", int'(bus.br_cnt), 16);

        // Two entries [1,0]; flush with a matching resolve and a push.
        push(1'b0);
        chk("pre_flush_occupancy", int'(bus.occupancy), 2);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("flush_occupancy", int'(bus.occupancy), 0);
        chk("flush_br_cnt", int'(bus.br_cnt), 17);
        chk("flush_miss_cnt", int'(bus.miss_cnt), 2);

        // Occupancy 3 with a strobe pending, then asynchronous reset.
        push(1'b1); push(1'b1); push(1'b1); push(1'b1);
        resolve_ok(1'b1);
        chk("pre_rst_occupancy", int'(bus.occupancy), 3);
        rst = 1'b1;
        #1;
        chk("rst_upd_en", int'(bus.upd_en), 0);
        chk("rst_upd_result", int'(bus.upd_result), 0);
        chk("rst_mispredict", int'(bus.mispredict), 0);
        chk("rst_occupancy", int'(bus.occupancy), 0);
        chk("rst_br_cnt", int'(bus.br_cnt), 0);
        chk("rst_miss_cnt", int'(bus.miss_cnt), 0);
        chk("rst_err_overflow", int'(bus.err_overflow), 0);
        chk("rst_err_underflow", int'(bus.err_underflow), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bp_resolve_queue.md
Name: bp_resolve_queue

Overview:
- Sits directly upstream of the 1-bit branch predictor.
- Records each prediction issued at fetch in program-order FIFO entries.
- When a branch resolves in execute, pops the oldest entry, compares it with the actual outcome, and drives the predictor's update strobe and outcome.
- Flags mispredictions, flushes wrong-path entries, and keeps saturating branch and mispredict statistics.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); pointer width.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- pred_valid  input  1  a branch was predicted this cycle; enqueue request.
- pred_taken  input  1  prediction for that branch (1 = taken); sourced from the predictor's predict output.
- pred_ready  output  1  queue can accept an entry; equals count < DEPTH.
- res_valid  input  1  oldest outstanding branch resolved this cycle; resolutions arrive in program order.
- res_taken  input  1  actual outcome (1 = taken).
- flush  input  1  external pipeline flush; discards all entries.
- upd_en  output  1  registered one-cycle update strobe; drives the predictor's en.
- upd_result  output  1  registered actual outcome; drives the predictor's result.
- mispredict  output  1  registered one-cycle pulse; asserted when head prediction != res_taken.
- occupancy  output  PTR_W+1  current entry count, 0..DEPTH.
- br_cnt  output  CNT_W  resolved-branch count, saturating.
- miss_cnt  output  CNT_W  mispredict count, saturating.
- err_overflow  output  1  sticky: enqueue attempted while full.
- err_underflow  output  1  sticky: resolution received while empty.

Behaviour:
- Reset (async, rst=1): rd_ptr = 0, wr_ptr = 0, count = 0. upd_en, upd_result, mispredict, br_cnt, miss_cnt, err_overflow and err_underflow all 0. Storage contents are don't-care.
- Circular buffer:
  - Pointers wrap modulo DEPTH.
  - count is explicit, PTR_W+1 bits wide.
  - occupancy = count; pred_ready = (count != DEPTH), combinational from registered count.
- Enqueue:
  - Condition: pred_valid && pred_ready && !kill, where kill = flush || (resolve && head != res_taken).
  - Action: mem[wr_ptr] <= pred_taken; wr_ptr++.
  - pred_valid while full: entry dropped, err_overflow <= 1.
  - No bypass: a push while full is rejected even if a pop occurs the same cycle.
- Resolve (res_valid && count != 0):
  - Pop the head.
  - Next cycle: upd_en = 1, upd_result = res_taken, mispredict = (mem[rd_ptr] != res_taken).
  - Latency exactly 1 clock from res_valid to upd_en; all three outputs deassert the following cycle unless another resolve occurs.
  - Back-to-back resolves produce back-to-back strobes.
- Resolve while empty:
  - No update, no pop.
  - err_underflow <= 1.
  - A same-cycle enqueue still proceeds; a resolution never matches a same-cycle enqueue.
- Mispredict recovery:
  - On a resolve whose head mismatches, all younger entries are wrong-path.
  - At the same edge: count <= 0, rd_ptr <= wr_ptr.
  - Any same-cycle enqueue is discarded.
- Flush:
  - count <= 0, rd_ptr <= wr_ptr; same-cycle enqueue discarded.
  - flush with a valid resolve: the resolve is processed normally (update, counters, mispredict) and the queue still ends empty.
- Count update:
  - Normal case: count_next = count + push - pop.
  - If kill is set: count_next = 0.
- Statistics:
  - br_cnt increments on each valid resolve.
  - miss_cnt increments on each mispredicting resolve.
  - Both hold at all-ones (saturate, no wrap).
- Sticky flags clear only on rst.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any pending upd_en is cancelled.
- The predictor consuming upd_en updates at the edge after the strobe, so it predicts from the new state one cycle after that edge.

Test Plan:
- Reset, then 3 pushes with pred_taken = 1,0,1 -> occupancy = 3; pred_ready = 1.
- Resolves res_taken = 1, 0 on consecutive cycles -> upd_en high 2 cycles, upd_result = 1 then 0, mispredict = 0, br_cnt = 2, occupancy = 1.
- Fill DEPTH = 4 entries of 1; resolve with res_taken = 0 -> next cycle mispredict = 1 and upd_result = 0; occupancy = 0; miss_cnt = 1. A push in the same cycle is discarded.
- Fill to 4, assert pred_valid once more -> pred_ready = 0, entry dropped, err_overflow = 1 and held; pointer wrap verified with a further 8 push/pop pairs, all matching.
- Empty queue, res_valid = 1 -> no upd_en, err_underflow = 1; a simultaneous push gives occupancy = 1.
- 2 entries, assert flush together with a matching resolve -> upd_en = 1, mispredict = 0, br_cnt +1, occupancy = 0. Assert rst while occupancy = 3 -> all outputs 0 immediately.
